// File: rtl/axi_lite_master.sv
// AXI-Lite initiator: one single-beat user command at a time onto AR/R or AW/W/B.
// Optional handshake timeout is compiled in with AXI_MASTER_TIMEOUT_EN.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDR_RANGE
`define ADDR_RANGE `ADDR_WIDTH-1:0
`endif
`ifndef DATA_RANGE
`define DATA_RANGE `DATA_WIDTH-1:0
`endif

module axi_lite_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               m_clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [`ADDR_RANGE] cmd_addr,
    input  logic [`DATA_RANGE] cmd_wdata,
    output logic               rsp_valid,
    output logic [`DATA_RANGE] rsp_rdata,
    output logic [3:0]         rsp_resp,
    output logic               rsp_err,
    output logic [`ADDR_RANGE] read_address,
    output logic               AR_VALID,
    input  logic               AR_READY,
    input  logic [`DATA_RANGE] data_read,
    input  logic               R_VALID,
    output logic               R_READY,
    output logic [`ADDR_RANGE] write_address,
    output logic               AW_VALID,
    input  logic               AW_READY,
    output logic [`DATA_RANGE] write_data,
    output logic               W_VALID,
    input  logic               W_READY,
    input  logic               B_VALID,
    input  logic [3:0]         BRESPONSE,
    output logic               B_READY
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

    typedef struct packed {
        logic               valid;
        logic [`DATA_RANGE] rdata;
        logic [3:0]         resp;
        logic               err;
    } rsp_t;

    state_t             state_q, state_d;
    rsp_t               rsp_q, rsp_d;
    logic               cmd_ready_d;
    logic               ar_valid_d, r_ready_d, aw_valid_d, w_valid_d, b_ready_d;
    logic [`ADDR_RANGE] raddr_d, waddr_d;
    logic [`DATA_RANGE] wdata_d;
    logic               aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic               aw_fin, w_fin;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] tmr_q, tmr_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    assign rsp_valid = rsp_q.valid;
    assign rsp_rdata = rsp_q.rdata;
    assign rsp_resp  = rsp_q.resp;
    assign rsp_err   = rsp_q.err;

    // A write phase counts as done if it completed earlier or completes on this edge.
    assign aw_fin = aw_done_q | (AW_VALID & AW_READY);
    assign w_fin  = w_done_q  | (W_VALID  & W_READY);

    always_ff @(posedge m_clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rsp_q         <= '0;
            cmd_ready     <= 1'b1;
            AR_VALID      <= 1'b0;
            R_READY       <= 1'b0;
            AW_VALID      <= 1'b0;
            W_VALID       <= 1'b0;
            B_READY       <= 1'b0;
            read_address  <= '0;
            write_address <= '0;
            write_data    <= '0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
            tmr_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rsp_q         <= rsp_d;
            cmd_ready     <= cmd_ready_d;
            AR_VALID      <= ar_valid_d;
            R_READY       <= r_ready_d;
            AW_VALID      <= aw_valid_d;
            W_VALID       <= w_valid_d;
            B_READY       <= b_ready_d;
            read_address  <= raddr_d;
            write_address <= waddr_d;
            write_data    <= wdata_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
`ifdef AXI_MASTER_TIMEOUT_EN
            tmr_q         <= tmr_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        rsp_d       = rsp_q;
        rsp_d.valid = 1'b0;
        rsp_d.err   = 1'b0;
        cmd_ready_d = cmd_ready;
        ar_valid_d  = AR_VALID;
        r_ready_d   = R_READY;
        aw_valid_d  = AW_VALID;
        w_valid_d   = W_VALID;
        b_ready_d   = B_READY;
        raddr_d     = read_address;
        waddr_d     = write_address;
        wdata_d     = write_data;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    cmd_ready_d = 1'b0;
                    if (cmd_write) begin
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        waddr_d    = cmd_addr;
                        wdata_d    = cmd_wdata;
                        aw_done_d  = 1'b0;
                        w_done_d   = 1'b0;
                        state_d    = WR_REQ;
                    end else begin
                        ar_valid_d = 1'b1;
                        raddr_d    = cmd_addr;
                        state_d    = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (AR_VALID && AR_READY) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = RD_DATA;
                end
            end
            RD_DATA: begin
                if (R_VALID && R_READY) begin
                    rsp_d.valid = 1'b1;
                    rsp_d.rdata = data_read;
                    rsp_d.resp  = 4'd0;
                    r_ready_d   = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            WR_REQ: begin
                if (AW_VALID && AW_READY) begin
                    aw_valid_d = 1'b0;
                    aw_done_d  = 1'b1;
                end
                if (W_VALID && W_READY) begin
                    w_valid_d = 1'b0;
                    w_done_d  = 1'b1;
                end
                if (aw_fin && w_fin) begin
                    b_ready_d = 1'b1;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (B_VALID && B_READY) begin
                    rsp_d.valid = 1'b1;
                    rsp_d.rdata = '0;
                    rsp_d.resp  = BRESPONSE;
                    b_ready_d   = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef AXI_MASTER_TIMEOUT_EN
        // Counter restarts on every state change; a stalled handshake aborts the whole command.
        tmr_d = '0;
        if (state_q != IDLE && state_d == state_q) begin
            tmr_d = tmr_q + 1'b1;
            if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                tmr_d       = '0;
                ar_valid_d  = 1'b0;
                r_ready_d   = 1'b0;
                aw_valid_d  = 1'b0;
                w_valid_d   = 1'b0;
                b_ready_d   = 1'b0;
                rsp_d.valid = 1'b1;
                rsp_d.err   = 1'b1;
                rsp_d.rdata = '0;
                rsp_d.resp  = 4'd0;
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
        end
`endif
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: reactive memory slave with per-command stall knobs,
// a queue-based response model and a per-cycle protocol/response checker.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDR_RANGE
`define ADDR_RANGE `ADDR_WIDTH-1:0
`endif
`ifndef DATA_RANGE
`define DATA_RANGE `DATA_WIDTH-1:0
`endif

module tb_axi_lite_master;
    localparam int MEM_N = 2 ** `ADDR_WIDTH;

    logic               m_clk = 1'b0, rst = 1'b1;
    logic               cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [`ADDR_RANGE] cmd_addr = '0;
    logic [`DATA_RANGE] cmd_wdata = '0;
    logic               rsp_valid, rsp_err;
    logic [`DATA_RANGE] rsp_rdata;
    logic [3:0]         rsp_resp;
    logic [`ADDR_RANGE] read_address, write_address;
    logic [`DATA_RANGE] write_data, data_read;
    logic               AR_VALID, AR_READY, R_VALID, R_READY;
    logic               AW_VALID, AW_READY, W_VALID, W_READY;
    logic               B_VALID, B_READY;
    logic [3:0]         BRESPONSE;

    always #5 m_clk = ~m_clk;

    axi_lite_master #(.TIMEOUT_CYCLES(16)) dut (
        .m_clk(m_clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_err(rsp_err),
        .read_address(read_address), .AR_VALID(AR_VALID), .AR_READY(AR_READY),
        .data_read(data_read), .R_VALID(R_VALID), .R_READY(R_READY),
        .write_address(write_address), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
        .write_data(write_data), .W_VALID(W_VALID), .W_READY(W_READY),
        .B_VALID(B_VALID), .BRESPONSE(BRESPONSE), .B_READY(B_READY)
    );

    int checks = 0, errors = 0, cyc = 0;

    // Stall knobs for the slave, set per command by the driver.
    int       ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [3:0] b_code = 4'd3;
    bit       stuck = 0;

    typedef struct {
        logic [`DATA_RANGE] rdata;
        logic [3:0]         resp;
        bit                 err;
        bit                 fast;
        int                 t0;
    } exp_t;
    exp_t expq[$];
    logic [`DATA_RANGE] model_mem [MEM_N];
    logic [`DATA_RANGE] smem [MEM_N];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_dly(input int a, input int r, input int aw, input int w, input int b,
                           input logic [3:0] bc);
        ar_dly = a; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b; b_code = bc;
    endtask

    // Default slave contents: each byte repeats the low nibble of its address.
    initial begin
        for (int i = 0; i < MEM_N; i++) begin
            smem[i]      = `DATA_WIDTH'({i[3:0], i[3:0]});
            model_mem[i] = `DATA_WIDTH'({i[3:0], i[3:0]});
        end
    end

    // Slave: reacts 2 time units after each edge, using handshakes seen before that edge.
    initial begin
        bit ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
        bit r_pend = 0, b_pend = 0, aw_got = 0, w_got = 0;
        int r_wait = 0, b_wait = 0, ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
        logic [`ADDR_RANGE] s_raddr = '0, s_waddr = '0;
        logic [`DATA_RANGE] s_wdata = '0;
        AR_READY = 0; R_VALID = 0; AW_READY = 0; W_READY = 0; B_VALID = 0;
        data_read = '0; BRESPONSE = '0;
        forever begin
            @(posedge m_clk); #2;
            if (rst) begin
                AR_READY = 0; R_VALID = 0; AW_READY = 0; W_READY = 0; B_VALID = 0;
                ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
                r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
                continue;
            end
            if (ar_hs) begin r_pend = 1; r_wait = r_dly; end
            if (r_hs) R_VALID = 0;
            if (aw_hs) aw_got = 1;
            if (w_hs) w_got = 1;
            if (aw_got && w_got) begin
                smem[s_waddr] = s_wdata;
                aw_got = 0; w_got = 0; b_pend = 1; b_wait = b_dly;
            end
            if (b_hs) B_VALID = 0;
            if (r_pend) begin
                if (r_wait == 0) begin R_VALID = 1; data_read = smem[s_raddr]; r_pend = 0; end
                else r_wait--;
            end else if (!R_VALID) data_read = `DATA_WIDTH'($urandom);
            if (b_pend) begin
                if (b_wait == 0) begin B_VALID = 1; BRESPONSE = b_code; b_pend = 0; end
                else b_wait--;
            end else if (!B_VALID) BRESPONSE = 4'($urandom);
            if (AR_VALID) begin AR_READY = !stuck && ar_cnt >= ar_dly; ar_cnt++; end
            else begin AR_READY = 0; ar_cnt = 0; end
            if (AW_VALID) begin AW_READY = aw_cnt >= aw_dly; aw_cnt++; end
            else begin AW_READY = 0; aw_cnt = 0; end
            if (W_VALID) begin W_READY = w_cnt >= w_dly; w_cnt++; end
            else begin W_READY = 0; w_cnt = 0; end
            ar_hs = AR_VALID && AR_READY;
            r_hs  = R_VALID && R_READY;
            aw_hs = AW_VALID && AW_READY;
            w_hs  = W_VALID && W_READY;
            b_hs  = B_VALID && B_READY;
            if (ar_hs) s_raddr = read_address;
            if (aw_hs) s_waddr = write_address;
            if (w_hs)  s_wdata = write_data;
        end
    end

    // Checker: model queue for responses plus handshake-stability rules, every cycle.
    initial begin
        bit rst_chk = 0, p_rst = 1;
        logic p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0;
        logic p_rr = 0, p_rv = 0, p_br = 0, p_bv = 0;
        logic [`ADDR_RANGE] p_raddr = '0, p_waddr = '0;
        logic [`DATA_RANGE] p_wdata = '0;
        exp_t e;
        forever begin
            @(negedge m_clk);
            cyc++;
            if (rst) begin
                expq.delete();
                rst_chk = 1;
            end else begin
                if (rst_chk) begin
                    chk("reset_outputs",
                        {cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_err, AR_VALID, R_READY,
                         AW_VALID, W_VALID, B_READY, read_address, write_address, write_data},
                        {1'b1, 1'b0, {`DATA_WIDTH{1'b0}}, 4'd0, 1'b0, 5'd0,
                         {`ADDR_WIDTH{1'b0}}, {`ADDR_WIDTH{1'b0}}, {`DATA_WIDTH{1'b0}}});
                    rst_chk = 0;
                end
                if (rsp_valid) begin
                    if (expq.size() == 0) chk("spurious_rsp_valid", 1, 0);
                    else begin
                        e = expq.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_resp", rsp_resp, e.resp);
                        chk("rsp_err", rsp_err, e.err);
                        if (e.fast) chk("min_latency", cyc - e.t0, 3);
                    end
                end
                chk("cmd_ready", cmd_ready, expq.size() == 0);
                if (!p_rst && !stuck) begin
                    if (p_arv && !p_arr) chk("ar_stable", {AR_VALID, read_address}, {1'b1, p_raddr});
                    if (p_awv && !p_awr) chk("aw_stable", {AW_VALID, write_address}, {1'b1, p_waddr});
                    if (p_wv && !p_wr) chk("w_stable", {W_VALID, write_data}, {1'b1, p_wdata});
                    if (p_rr && !p_rv) chk("r_ready_held", R_READY, 1);
                    if (p_br && !p_bv) chk("b_ready_held", B_READY, 1);
                end
                if (cmd_valid && cmd_ready) begin
                    e.err  = stuck;
                    e.fast = !stuck && (ar_dly + r_dly + aw_dly + w_dly + b_dly) == 0;
                    e.t0   = cyc;
                    if (cmd_write) begin
                        model_mem[cmd_addr] = cmd_wdata;
                        e.rdata = '0;
                        e.resp  = b_code;
                    end else begin
                        e.rdata = stuck ? '0 : model_mem[cmd_addr];
                        e.resp  = 4'd0;
                    end
                    expq.push_back(e);
                end
            end
            p_rst = rst;
            p_arv = AR_VALID; p_arr = AR_READY; p_raddr = read_address;
            p_awv = AW_VALID; p_awr = AW_READY; p_waddr = write_address;
            p_wv = W_VALID; p_wr = W_READY; p_wdata = write_data;
            p_rr = R_READY; p_rv = R_VALID; p_br = B_READY; p_bv = B_VALID;
        end
    end

    // Issue one command and wait for its response, counting cycles each channel signal is high.
    task automatic run_cmd(input bit wr, input logic [`ADDR_RANGE] addr,
                           input logic [`DATA_RANGE] data,
                           output int n_ar, output int n_rr, output int n_aw, output int n_w,
                           output logic [`DATA_RANGE] rd, output logic [3:0] rs, output logic er);
        int guard = 0;
        n_ar = 0; n_rr = 0; n_aw = 0; n_w = 0; rd = '0; rs = '0; er = 0;
        while (!cmd_ready && guard < 200) begin @(posedge m_clk); #1; guard++; end
        if (!cmd_ready) begin chk("cmd_ready_wait", 0, 1); return; end
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
        @(posedge m_clk); #1;
        cmd_valid = 0;
        guard = 0;
        while (guard < 300) begin
            n_ar += int'(AR_VALID); n_rr += int'(R_READY);
            n_aw += int'(AW_VALID); n_w += int'(W_VALID);
            if (rsp_valid) break;
            @(posedge m_clk); #1; guard++;
        end
        if (!rsp_valid) begin chk("rsp_wait", 0, 1); return; end
        rd = rsp_rdata; rs = rsp_resp; er = rsp_err;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ar, n_rr, n_aw, n_w, pulses;
        logic [`DATA_RANGE] rd;
        logic [3:0] rs;
        logic er;
        repeat (3) @(posedge m_clk);
        #1 rst = 0;

        // Default contents, always-ready slave.
        set_dly(0, 0, 0, 0, 0, 4'd3);
        run_cmd(0, 8'd5, 8'h00, n_ar, n_rr, n_aw, n_w, rd, rs, er);
        chk("read5_rdata", rd, 8'h55);
        chk("read5_resp", rs, 4'd0);
        chk("read5_ar_cycles", n_ar, 1);
        chk("read5_rready_cycles", n_rr, 1);

        run_cmd(1, 8'd2, 8'h3C, n_ar, n_rr, n_aw, n_w, rd, rs, er);
        chk("write2_resp", rs, 4'd3);
        chk("write2_err", er, 0);
        chk("write2_rdata", rd, 8'h00);
        run_cmd(0, 8'd2, 8'h00, n_ar, n_rr, n_aw, n_w, rd, rs, er);
        chk("read2_rdata", rd, 8'h3C);

        // AW held off three cycles while W is taken at once.
        set_dly(0, 0, 3, 0, 0, 4'd3);
        run_cmd(1, 8'd9, 8'hA7, n_ar, n_rr, n_aw, n_w, rd, rs, er);
        chk("awdly_aw_cycles", n_aw, 4);
        chk("awdly_w_cycles", n_w, 1);
        chk("awdly_resp", rs, 4'd3);

        // R held off five cycles.
        set_dly(0, 5, 0, 0, 0, 4'd3);
        run_cmd(0, 8'd9, 8'h00, n_ar, n_rr, n_aw, n_w, rd, rs, er);
        chk("rdly_rready_cycles", n_rr, 6);
        chk("rdly_rdata", rd, 8'hA7);

        // Reset while waiting in the read-data phase: command dropped, no response.
        set_dly(0, 10, 0, 0, 0, 4'd3);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 8'd4;
        @(posedge m_clk); #1;
        cmd_valid = 0;
        for (int i = 0; i < 20 && !R_READY; i++) begin @(posedge m_clk); #1; end
        chk("rst_test_in_rd_data", R_READY, 1);
        rst = 1;
        @(posedge m_clk); #1;
        rst = 0;
        chk("rst_mid_outputs", {cmd_ready, AR_VALID, R_READY, AW_VALID, W_VALID, B_READY, rsp_valid},
            7'b1000000);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin pulses += int'(rsp_valid); @(posedge m_clk); #1; end
        chk("rst_mid_no_rsp", pulses, 0);

`ifdef AXI_MASTER_TIMEOUT_EN
        set_dly(0, 0, 0, 0, 0, 4'd3);
        stuck = 1;
        run_cmd(0, 8'd6, 8'h00, n_ar, n_rr, n_aw, n_w, rd, rs, er);
        chk("timeout_err", er, 1);
        chk("timeout_ar_cycles", n_ar, 16);
        chk("timeout_ar_dropped", AR_VALID, 0);
        chk("timeout_idle", cmd_ready, 1);
        @(posedge m_clk); #1;
        stuck = 0;
`endif

        // Random commands over a small address window so reads hit earlier writes.
        for (int k = 0; k < 150; k++) begin
            logic [3:0] bc;
            bc = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd3;
            if ($urandom_range(0, 2) == 0) set_dly(0, 0, 0, 0, 0, bc);
            else set_dly($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                         $urandom_range(0, 4), $urandom_range(0, 4), bc);
            run_cmd(1'($urandom_range(0, 1)), `ADDR_WIDTH'($urandom_range(0, 15)),
                    `DATA_WIDTH'($urandom), n_ar, n_rr, n_aw, n_w, rd, rs, er);
        end

        repeat (4) @(posedge m_clk);
        chk("queue_drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
